// File: rtl/mdu_mul_ctrl.sv
// Issue/response controller between EX and the iterative 64-bit multiplier.
// Decodes the MUL group, drives the multiplier handshake, selects the result and keeps a one-entry product cache.
module mdu_mul_ctrl #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            ex_valid,
   input  logic [2:0]      ex_op,
   input  logic            ex_word,
   input  logic [XLEN-1:0] ex_src1,
   input  logic [XLEN-1:0] ex_src2,
   output logic            ex_stall,
   output logic            res_valid,
   output logic [XLEN-1:0] res_data,
   output logic            mul_valid,
   output logic            mulw,
   output logic [1:0]      mul_signed,
   output logic [XLEN-1:0] multiplicand,
   output logic [XLEN-1:0] multiplier,
   output logic            mul_flush,
   input  logic            mul_ready,
   input  logic [XLEN-1:0] result_hi,
   input  logic [XLEN-1:0] result_lo,
   output logic [1:0]      dbg_state
);

   // Handshake: a request transfers on a cycle with mul_valid & mul_ready; mul_ready then stays
   // low while the multiplier works, and the cycle it reads 1 again result_hi/lo hold the product.

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
   typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_WORD} sel_t;

   state_t state, state_nxt;
   sel_t   sel, dec_sel;

   logic            req;
   logic            dec_word;
   logic [1:0]      dec_signed;
   logic            cache_hit;
   logic [XLEN-1:0] hit_data;
   logic [XLEN-1:0] wait_data;

   logic            c_valid;
   logic [XLEN-1:0] c_src1, c_src2, c_hi, c_lo;
   logic [1:0]      c_signed;
   logic            c_mulw;

   assign req = ex_valid & ~ex_op[2] & ~flush;

   always_comb begin
      dec_word   = ex_word & (ex_op[1:0] == 2'b00);
      dec_signed = 2'b11;
      dec_sel    = SEL_HI;
      case (ex_op[1:0])
         2'b10:   dec_signed = 2'b10;
         2'b11:   dec_signed = 2'b00;
         default: dec_signed = 2'b11;
      endcase
      if (dec_word)
         dec_sel = SEL_WORD;
      else if (ex_op[1:0] == 2'b00)
         dec_sel = SEL_LO;
      // The low 64 bits of a product do not depend on operand signedness.
      cache_hit = c_valid & (c_src1 == ex_src1) & (c_src2 == ex_src2) & (c_mulw == dec_word)
                & ((dec_sel == SEL_LO) | (c_signed == dec_signed));
      case (dec_sel)
         SEL_HI:   hit_data = c_hi;
         SEL_WORD: hit_data = {{(XLEN-32){c_lo[31]}}, c_lo[31:0]};
         default:  hit_data = c_lo;
      endcase
      case (sel)
         SEL_HI:   wait_data = result_hi;
         SEL_WORD: wait_data = {{(XLEN-32){result_lo[31]}}, result_lo[31:0]};
         default:  wait_data = result_lo;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (req) state_nxt = cache_hit ? S_RESP : S_ISSUE;
         S_ISSUE: if (mul_ready) state_nxt = S_WAIT;
         S_WAIT:  if (mul_ready) state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush)
         state_nxt = S_IDLE;
   end

   assign mul_valid = (state == S_ISSUE) & ~flush;
   assign mul_flush = flush & ((state == S_ISSUE) | (state == S_WAIT));
   assign res_valid = (state == S_RESP) & ~flush;
   assign ex_stall  = req & (state != S_RESP);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         mulw         <= 1'b0;
         mul_signed   <= 2'b00;
         multiplicand <= '0;
         multiplier   <= '0;
         sel          <= SEL_LO;
         res_data     <= '0;
         c_valid      <= 1'b0;
         c_src1       <= '0;
         c_src2       <= '0;
         c_signed     <= 2'b00;
         c_mulw       <= 1'b0;
         c_hi         <= '0;
         c_lo         <= '0;
      end else begin
         if ((state == S_IDLE) && req) begin
            multiplicand <= ex_src1;
            multiplier   <= ex_src2;
            mul_signed   <= dec_signed;
            mulw         <= dec_word;
            sel          <= dec_sel;
            if (cache_hit)
               res_data <= hit_data;
         end
         // A squashed operation never lands in the cache.
         if ((state == S_WAIT) && mul_ready && !flush) begin
            c_valid  <= 1'b1;
            c_src1   <= multiplicand;
            c_src2   <= multiplier;
            c_signed <= mul_signed;
            c_mulw   <= mulw;
            c_hi     <= result_hi;
            c_lo     <= result_lo;
            res_data <= wait_data;
         end
      end
   end

endmodule

// File: tb/tb_mdu_mul_ctrl.sv
// Bench for mdu_mul_ctrl: directed test-plan steps plus random operations against an arithmetic reference,
// with a behavioural iterative multiplier of random latency on the far side of the handshake.
module tb_mdu_mul_ctrl;

   logic        clk = 1'b0;
   logic        rst, flush, ex_valid, ex_word;
   logic [2:0]  ex_op;
   logic [63:0] ex_src1, ex_src2;
   logic        ex_stall, res_valid, mul_valid, mulw, mul_flush, mul_ready;
   logic [63:0] res_data, multiplicand, multiplier, result_hi, result_lo;
   logic [1:0]  mul_signed, dbg_state;

   int n_tests = 0;
   int n_fail  = 0;
   int acc_count = 0;

   logic        cm_valid;
   logic [63:0] cm_a, cm_b;
   logic [1:0]  cm_op;
   logic        cm_w;
   logic [63:0] last_res;

   always #5 clk = ~clk;

   mdu_mul_ctrl #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .ex_op(ex_op), .ex_word(ex_word),
      .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_stall(ex_stall), .res_valid(res_valid),
      .res_data(res_data), .mul_valid(mul_valid), .mulw(mulw), .mul_signed(mul_signed),
      .multiplicand(multiplicand), .multiplier(multiplier), .mul_flush(mul_flush),
      .mul_ready(mul_ready), .result_hi(result_hi), .result_lo(result_lo), .dbg_state(dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] sig_of(input logic [1:0] op);
      case (op)
         2'd2:    return 2'b10;
         2'd3:    return 2'b00;
         default: return 2'b11;
      endcase
   endfunction

   function automatic logic [127:0] ext(input logic [63:0] v, input logic s);
      return s ? {{64{v[63]}}, v} : {64'd0, v};
   endfunction

   // Architectural result of the instruction, straight from the ISA definitions.
   function automatic logic [63:0] ref_result(input logic [1:0] op, input logic w,
                                              input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [1:0]   s;
      if (w && op == 2'd0) begin
         p = {96'd0, a[31:0]} * {96'd0, b[31:0]};
         return {{32{p[31]}}, p[31:0]};
      end
      s = sig_of(op);
      p = ext(a, s[1]) * ext(b, s[0]);
      return (op == 2'd0) ? p[63:0] : p[127:64];
   endfunction

   function automatic logic predict_hit(input logic [1:0] op, input logic weff,
                                        input logic [63:0] a, input logic [63:0] b);
      if (!cm_valid || a != cm_a || b != cm_b || weff != cm_w) return 1'b0;
      if (op == 2'd0 && !weff) return 1'b1;
      return sig_of(op) == sig_of(cm_op);
   endfunction

   // Iterative multiplier: accepts on valid & ready, busy 1..4 cycles, results valid when ready returns.
   initial begin : mult_model
      logic        acc_s, fl_s, busy, mw;
      logic [63:0] ma, mb;
      logic [1:0]  ms;
      logic [127:0] p;
      int          cnt, rec;
      mul_ready = 1'b1; result_hi = '0; result_lo = '0;
      busy = 1'b0; cnt = 0; rec = 0; ma = '0; mb = '0; ms = '0; mw = 1'b0;
      forever begin
         @(negedge clk); #3;
         acc_s = mul_valid && mul_ready;
         fl_s  = mul_flush || rst;
         if (acc_s && !fl_s) begin
            acc_count++;
            ma = multiplicand; mb = multiplier; ms = mul_signed; mw = mulw;
         end
         @(posedge clk); #1;
         if (fl_s) begin
            busy = 1'b0; rec = $urandom_range(1, 3); mul_ready = 1'b0;
         end else if (acc_s) begin
            busy = 1'b1; cnt = $urandom_range(1, 4); mul_ready = 1'b0;
            result_hi = {$urandom, $urandom}; result_lo = {$urandom, $urandom};
         end else if (busy) begin
            if (cnt <= 1) begin
               busy = 1'b0; mul_ready = 1'b1;
               if (mw) p = ext({{32{ma[31]}}, ma[31:0]}, 1'b1) * ext({{32{mb[31]}}, mb[31:0]}, 1'b1);
               else    p = ext(ma, ms[1]) * ext(mb, ms[0]);
               result_hi = p[127:64]; result_lo = p[63:0];
            end else begin
               cnt--;
               result_hi = {$urandom, $urandom}; result_lo = {$urandom, $urandom};
            end
         end else if (rec > 0) begin
            rec--;
            if (rec == 0) mul_ready = 1'b1;
         end
      end
   end

   task automatic do_op(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
      logic        weff, exp_hit, got, mv_seen;
      logic [63:0] exp;
      int          acc0, k;
      weff    = w && (op == 2'd0);
      exp_hit = predict_hit(op, weff, a, b);
      exp     = ref_result(op, w, a, b);
      @(posedge clk); #1;
      acc0 = acc_count; mv_seen = 1'b0; got = 1'b0; k = 0;
      ex_valid = 1'b1; ex_op = {1'b0, op}; ex_word = w; ex_src1 = a; ex_src2 = b;
      while (!got && k < 80) begin
         @(negedge clk);
         if (k == 0) check("stall_in_idle", ex_stall, 1);
         if (k == 1) begin
            check("mul_signed", mul_signed, sig_of(op));
            check("mulw", mulw, weff);
            check("multiplicand", multiplicand, a);
            check("multiplier", multiplier, b);
         end
         if (mul_valid) mv_seen = 1'b1;
         if (res_valid) begin
            got = 1'b1;
            last_res = res_data;
            check("res_data", res_data, exp);
            check("stall_in_resp", ex_stall, 0);
            if (exp_hit) check("hit_latency", k, 1);
         end
         k++;
      end
      if (!got) check("res_timeout", res_valid, 1);
      check("accept_count", acc_count - acc0, exp_hit ? 0 : 1);
      if (exp_hit) check("hit_no_mul_valid", mv_seen, 0);
      @(posedge clk); #1;
      ex_valid = 1'b0;
      @(negedge clk);
      check("res_single_pulse", res_valid, 0);
      if (!exp_hit) begin
         cm_valid = 1'b1; cm_a = a; cm_b = b; cm_op = op; cm_w = weff;
      end
   endtask

   task automatic start_and_reach_wait(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
      int k;
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = {1'b0, op}; ex_word = 1'b0; ex_src1 = a; ex_src2 = b;
      k = 0;
      while (!(dbg_state == 2'd2 && mul_ready == 1'b0) && k < 60) begin
         @(negedge clk);
         k++;
      end
      check("reach_wait", dbg_state, 2'd2);
   endtask

   initial begin : main
      logic [1:0]  op;
      logic        w;
      logic [63:0] a, b, pa, pb;
      rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; ex_op = '0; ex_word = 1'b0;
      ex_src1 = '0; ex_src2 = '0; cm_valid = 1'b0; cm_a = '0; cm_b = '0; cm_op = '0; cm_w = 1'b0;
      last_res = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_state", dbg_state, 0);
      check("rst_res_data", res_data, 0);
      check("rst_mul_signed", mul_signed, 0);
      check("rst_multiplicand", multiplicand, 0);
      check("rst_mul_valid", mul_valid, 0);
      check("rst_ex_stall", ex_stall, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_op(2'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB);
      check("tp_mul", last_res, 64'hFFFF_FFFF_FFFF_FFF1);
      do_op(2'd3, 1'b0, '1, '1);
      check("tp_mulhu", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(2'd0, 1'b0, '1, '1);
      check("tp_mul_hit", last_res, 64'd1);
      do_op(2'd2, 1'b0, '1, 64'd2);
      check("tp_mulhsu", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op(2'd1, 1'b0, '1, 64'd2);
      check("tp_mulh_miss", last_res, 64'hFFFF_FFFF_FFFF_FFFF);
      do_op(2'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2);
      check("tp_mulw", last_res, 64'hFFFF_FFFF_FFFF_FFFE);

      // Squash a MUL in flight, prove the cache still holds the MULW, then reissue.
      start_and_reach_wait(2'd0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
      flush = 1'b1; #1;
      check("flush_mul_flush", mul_flush, 1);
      check("flush_res_valid", res_valid, 0);
      check("flush_ex_stall", ex_stall, 0);
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_flush_idle", dbg_state, 0);
         check("post_flush_no_res", res_valid, 0);
      end
      do_op(2'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2);
      check("cache_kept_after_flush", last_res, 64'hFFFF_FFFF_FFFF_FFFE);
      do_op(2'd0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);

      // Flush arriving with a request in IDLE drops the request.
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = 3'b001; ex_src1 = 64'd77; ex_src2 = 64'd99; flush = 1'b1; #1;
      check("flush_req_stall", ex_stall, 0);
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b0;
      @(negedge clk);
      check("flush_req_idle", dbg_state, 0);
      check("flush_req_no_issue", mul_valid, 0);

      // ex_op[2] set belongs to the divider and is ignored here.
      @(posedge clk); #1;
      ex_valid = 1'b1; ex_op = 3'b100; ex_src1 = 64'd5; ex_src2 = 64'd7;
      repeat (2) begin
         @(negedge clk);
         check("div_op_stall", ex_stall, 0);
         check("div_op_idle", dbg_state, 0);
         check("div_op_no_issue", mul_valid, 0);
      end
      ex_valid = 1'b0;

      // Reset in WAIT clears everything including the cache.
      start_and_reach_wait(2'd0, 64'd11, 64'd13);
      rst = 1'b1; ex_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_wait_state", dbg_state, 0);
      check("rst_wait_res_data", res_data, 0);
      check("rst_wait_outputs", {res_valid, mul_valid, mulw, mul_flush, ex_stall, mul_signed}, 0);
      check("rst_wait_operands", multiplicand | multiplier, 0);
      cm_valid = 1'b0;
      do_op(2'd1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);

      pa = 64'd1; pb = 64'd1;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         w  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            a = pa; b = pb;
         end else begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = '1;
            if ($urandom_range(0, 3) == 0) b = 64'h8000_0000_0000_0000;
         end
         do_op(op, w, a, b);
         pa = a; pb = b;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
